// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice: funct3 width codes,
// FSM state encodings, the request owner type and the byte-enable helper.
package mem_arbiter_pkg;

  // Access width codes as carried on the LSU funct3 field
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Arbiter FSM state encodings
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_REQ  = 2'd1;
  localparam arb_state_t ST_RESP = 2'd2;

  // Which requester owns the single outstanding transaction
  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_LSU   = 1'b1
  } owner_e;

  // Byte enables: only sub-word stores narrow the lanes; loads always read
  // the full word and are shifted down afterwards.
  function automatic logic [3:0] byte_enable(input logic       we,
                                             input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b1111;
    if (we) begin
      case (funct3)
        F3_SB:   be = 4'b0001 << addr_lo;
        F3_SH:   be = 4'b0011 << {addr_lo[1], 1'b0};
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core (fetch + LSU), the arbiter and memory.
// slave: the arbiter's view. master: the surrounding core/memory view.
// The lsu_misaligned_o member exists only when MEM_ARB_MISALIGN_CHECK_EN is defined.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;

  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_busy_o;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  logic        lsu_misaligned_o;
`endif

  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_funct3_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, mem_busy_o,
    output mem_valid_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    , output lsu_misaligned_o
`endif
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_funct3_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, mem_busy_o,
    input  mem_valid_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    , input lsu_misaligned_o
`endif
  );
endinterface

// File: rtl/mem_lane_align.sv
// Lane steering for LSU accesses: byte enables, store data replication into
// byte/half lanes, and right-alignment of returned load data.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_offset,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_aligned
);

  // Replicate right-aligned store data so every candidate lane carries it
  always_comb begin
    be            = byte_enable(we, funct3, addr_lo);
    wdata_lanes   = wdata;
    case (funct3[1:0])
      2'b00:   wdata_lanes = {4{wdata[7:0]}};
      2'b01:   wdata_lanes = {2{wdata[15:0]}};
      default: wdata_lanes = wdata;
    endcase
    rdata_aligned = rdata >> {rd_offset, 3'b000};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch and LSU) in front of a single-ported
// memory with one outstanding transaction. LSU has priority, but fetch is
// forced through after STARVE_MAX consecutive LSU grants while it waits.
// Optional feature: define MEM_ARB_MISALIGN_CHECK_EN to answer misaligned
// LSU half/word accesses locally with lsu_misaligned_o instead of issuing them.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t  state_q;
  owner_e      owner_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  offset_q;
  logic [3:0]  starve_q;

  logic        fetch_wins;
  logic        if_gnt;
  logic        lsu_gnt;
  logic        resp_done;
  logic        lsu_rvalid;
  logic        mis_req;
  logic        mis_active;

  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata_lanes;
  logic [31:0] lsu_rdata_aligned;

  mem_lane_align u_align (
    .we            (bus.lsu_we_i),
    .funct3        (bus.lsu_funct3_i),
    .addr_lo       (bus.lsu_addr_i[1:0]),
    .wdata         (bus.lsu_wdata_i),
    .rd_offset     (offset_q),
    .rdata         (bus.mem_rdata_i),
    .be            (lsu_be),
    .wdata_lanes   (lsu_wdata_lanes),
    .rdata_aligned (lsu_rdata_aligned)
  );

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  logic mis_q;

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0
  always_comb begin
    mis_req = ((bus.lsu_funct3_i[1:0] == 2'b01) && bus.lsu_addr_i[0]) ||
              ((bus.lsu_funct3_i[1:0] == 2'b10) && (bus.lsu_addr_i[1:0] != 2'b00));
  end

  // Remember that the granted LSU access is answered locally, not by memory
  always_ff @(posedge clk) begin
    if (reset)          mis_q <= 1'b0;
    else if (lsu_gnt)   mis_q <= mis_req;
    else if (resp_done) mis_q <= 1'b0;
  end

  assign mis_active           = mis_q;
  assign bus.lsu_misaligned_o = lsu_rvalid && mis_q;
`else
  assign mis_req    = 1'b0;
  assign mis_active = 1'b0;
`endif

  // Arbitration and response decode; reset masks every handshake output
  always_comb begin
    fetch_wins = bus.if_req_i && (!bus.lsu_req_i || (starve_q == STARVE_LIM));
    if_gnt     = !reset && (state_q == ST_IDLE) && fetch_wins;
    lsu_gnt    = !reset && (state_q == ST_IDLE) && bus.lsu_req_i && !fetch_wins;
    resp_done  = !reset && (state_q == ST_RESP) && (bus.mem_rvalid_i || mis_active);
    lsu_rvalid = resp_done && (owner_q == OWNER_LSU);
  end

  assign bus.if_gnt_o     = if_gnt;
  assign bus.lsu_gnt_o    = lsu_gnt;
  assign bus.if_rvalid_o  = resp_done && (owner_q == OWNER_FETCH);
  assign bus.if_rdata_o   = bus.mem_rdata_i;
  assign bus.lsu_rvalid_o = lsu_rvalid;
  assign bus.lsu_rdata_o  = mis_active ? 32'h0 : lsu_rdata_aligned;
  assign bus.mem_busy_o   = !reset && !lsu_rvalid &&
                            (bus.lsu_req_i || ((owner_q == OWNER_LSU) && (state_q != ST_IDLE)));
  assign bus.mem_valid_o  = !reset && (state_q == ST_REQ);
  assign bus.mem_we_o     = we_q;
  assign bus.mem_be_o     = be_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;

  // Transaction FSM: grant and latch in IDLE, issue in REQ, await data in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWNER_FETCH;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      offset_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (if_gnt) begin
            owner_q  <= OWNER_FETCH;
            we_q     <= 1'b0;
            be_q     <= 4'b1111;
            addr_q   <= {bus.if_addr_i[31:2], 2'b00};
            wdata_q  <= 32'h0;
            offset_q <= 2'b00;
            state_q  <= ST_REQ;
          end else if (lsu_gnt) begin
            owner_q  <= OWNER_LSU;
            we_q     <= bus.lsu_we_i;
            be_q     <= lsu_be;
            addr_q   <= {bus.lsu_addr_i[31:2], 2'b00};
            wdata_q  <= lsu_wdata_lanes;
            offset_q <= bus.lsu_addr_i[1:0];
            state_q  <= mis_req ? ST_RESP : ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_ready_i) state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.mem_rvalid_i || mis_active) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Count LSU wins while fetch is kept waiting; saturates at the limit
  always_ff @(posedge clk) begin
    if (reset)                                  starve_q <= 4'd0;
    else if (!bus.if_req_i || if_gnt)           starve_q <= 4'd0;
    else if (lsu_gnt && (starve_q < STARVE_LIM)) starve_q <= starve_q + 4'd1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus tasks push expected memory
// requests and responses into queues; a monitor pops and compares them.
// Define MEM_ARB_MISALIGN_CHECK_EN to also exercise the misalignment path.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memreq_t;

  typedef struct {
    logic        check_data;
    logic [31:0] data;
    logic        misaligned;
  } resp_t;

  logic clk;
  logic reset;
  logic mem_auto;
  int   tests_run;
  int   tests_failed;

  memreq_t     memreq_q[$];
  resp_t       if_resp_q[$];
  resp_t       lsu_resp_q[$];
  logic [31:0] mem_model[logic [31:0]];

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic report_fail(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Memory model: always ready, answers one cycle after acceptance
  initial begin : mem_responder
    logic        acc;
    logic [31:0] a;
    bus.mem_ready_i  = 1'b1;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      acc = bus.mem_valid_o && bus.mem_ready_i && !reset;
      a   = bus.mem_addr_o;
      @(posedge clk);
      #1;
      if (mem_auto) begin
        bus.mem_rvalid_i = acc;
        bus.mem_rdata_i  = acc ? mem_read(a) : 32'h0;
      end
    end
  end

  // Monitor: compare every presented request/response against the queues
  initial begin : monitor
    memreq_t m;
    resp_t   r;
    forever begin
      @(negedge clk);
      if (bus.mem_valid_o && bus.mem_ready_i) begin
        if (memreq_q.size() == 0) report_fail("unexpected_mem_req", bus.mem_addr_o, 32'h0);
        else begin
          m = memreq_q.pop_front();
          check_output("mem_addr", bus.mem_addr_o, m.addr);
          check_output("mem_we", bus.mem_we_o, m.we);
          check_output("mem_be", bus.mem_be_o, m.be);
          if (m.we) check_output("mem_wdata", bus.mem_wdata_o, m.wdata);
        end
      end
      if (bus.if_rvalid_o) begin
        if (if_resp_q.size() == 0) report_fail("unexpected_if_rvalid", bus.if_rdata_o, 32'h0);
        else begin
          r = if_resp_q.pop_front();
          check_output("if_rdata", bus.if_rdata_o, r.data);
        end
      end
      if (bus.lsu_rvalid_o) begin
        if (lsu_resp_q.size() == 0) report_fail("unexpected_lsu_rvalid", bus.lsu_rdata_o, 32'h0);
        else begin
          r = lsu_resp_q.pop_front();
          if (r.check_data) check_output("lsu_rdata", bus.lsu_rdata_o, r.data);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
          check_output("lsu_misaligned", bus.lsu_misaligned_o, r.misaligned);
`endif
        end
      end
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      if (bus.lsu_misaligned_o && !bus.lsu_rvalid_o)
        report_fail("misaligned_without_rvalid", 32'h1, 32'h0);
`endif
    end
  end

  task automatic apply_fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                             input logic push_req, output int waits);
    resp_t   r;
    memreq_t m;
    r = '{check_data: 1'b1, data: exp_data, misaligned: 1'b0};
    if_resp_q.push_back(r);
    if (push_req) begin
      m = '{we: 1'b0, be: 4'b1111, addr: {addr[31:2], 2'b00}, wdata: 32'h0};
      memreq_q.push_back(m);
    end
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = addr;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.if_gnt_o) break;
      waits++;
      if (waits > 100) begin
        report_fail("if_gnt_timeout", 32'h0, 32'h1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.if_req_i = 1'b0;
  endtask

  task automatic apply_lsu(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic check_data,
                           input logic [31:0] exp_data, input logic exp_mis,
                           input logic push_req, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, output int waits);
    resp_t   r;
    memreq_t m;
    r = '{check_data: check_data, data: exp_data, misaligned: exp_mis};
    lsu_resp_q.push_back(r);
    if (push_req && !exp_mis) begin
      m = '{we: we, be: exp_be, addr: {addr[31:2], 2'b00}, wdata: exp_wdata};
      memreq_q.push_back(m);
    end
    bus.lsu_req_i    = 1'b1;
    bus.lsu_we_i     = we;
    bus.lsu_funct3_i = f3;
    bus.lsu_addr_i   = addr;
    bus.lsu_wdata_i  = wdata;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.lsu_gnt_o) break;
      waits++;
      if (waits > 100) begin
        report_fail("lsu_gnt_timeout", 32'h0, 32'h1);
        break;
      end
    end
    check_output("busy_at_lsu_grant", bus.mem_busy_o, 32'h1);
    @(posedge clk);
    #1;
    bus.lsu_req_i = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while ((memreq_q.size() + if_resp_q.size() + lsu_resp_q.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  initial begin : stimulus
    int      w;
    memreq_t m;
    tests_run    = 0;
    tests_failed = 0;
    mem_auto     = 1'b0;

    // Reset with every request and a stray memory response asserted
    reset            = 1'b1;
    bus.if_req_i     = 1'b1;
    bus.if_addr_i    = 32'h0000_0040;
    bus.lsu_req_i    = 1'b1;
    bus.lsu_we_i     = 1'b0;
    bus.lsu_funct3_i = F3_LW;
    bus.lsu_addr_i   = 32'h0000_0080;
    bus.lsu_wdata_i  = 32'h0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    check_output("reset_if_gnt", bus.if_gnt_o, 32'h0);
    check_output("reset_lsu_gnt", bus.lsu_gnt_o, 32'h0);
    check_output("reset_mem_valid", bus.mem_valid_o, 32'h0);
    check_output("reset_busy", bus.mem_busy_o, 32'h0);
    check_output("reset_if_rvalid", bus.if_rvalid_o, 32'h0);
    check_output("reset_lsu_rvalid", bus.lsu_rvalid_o, 32'h0);
    check_output("reset_mem_addr", bus.mem_addr_o, 32'h0);
    check_output("reset_mem_be", bus.mem_be_o, 32'h0);
    bus.if_req_i     = 1'b0;
    bus.lsu_req_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_auto = 1'b1;
    @(posedge clk);
    #1;

    // Lone fetch: grant at t0, mem_valid at t1, rvalid with data at t2
    mem_model[32'h0000_0100] = 32'hDEAD_BEEF;
    apply_fetch(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, w);
    check_output("fetch_grant_wait", w, 32'd0);
    @(negedge clk);
    check_output("fetch_t1_mem_valid", bus.mem_valid_o, 32'h1);
    @(negedge clk);
    check_output("fetch_t2_if_rvalid", bus.if_rvalid_o, 32'h1);
    wait_drained(20);

    // Directed LSU vectors: stores check lanes, loads check the shifted data
    apply_lsu(1'b1, F3_SB, 32'h0000_0203, 32'h0000_00AB, 1'b0, 32'h0, 1'b0, 1'b1,
              4'b1000, 32'hABAB_ABAB, w);
    wait_drained(20);
    mem_model[32'h0000_0300] = 32'h8001_1234;
    apply_lsu(1'b0, F3_LH, 32'h0000_0302, 32'h0, 1'b1, 32'h0000_8001, 1'b0, 1'b1,
              4'b1111, 32'h0, w);
    wait_drained(20);
    apply_lsu(1'b1, F3_SH, 32'h0000_0202, 32'h0000_1234, 1'b0, 32'h0, 1'b0, 1'b1,
              4'b1100, 32'h1234_1234, w);
    wait_drained(20);
    apply_lsu(1'b0, F3_LBU, 32'h0000_0101, 32'h0, 1'b1, 32'h00DE_ADBE, 1'b0, 1'b1,
              4'b1111, 32'h0, w);
    wait_drained(20);
    apply_lsu(1'b1, F3_SW, 32'h0000_0400, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 1'b1,
              4'b1111, 32'hCAFE_F00D, w);
    wait_drained(20);
    apply_lsu(1'b1, F3_SB, 32'h0000_0400, 32'h0000_0055, 1'b0, 32'h0, 1'b0, 1'b1,
              4'b0001, 32'h5555_5555, w);
    wait_drained(20);

    // Continuous contention: expect L L L L F L L L L F
    for (int k = 0; k < 4; k++) begin
      m = '{we: 1'b0, be: 4'b1111, addr: 32'h0000_1000 + 32'(4 * k), wdata: 32'h0};
      memreq_q.push_back(m);
    end
    m = '{we: 1'b0, be: 4'b1111, addr: 32'h0000_2000, wdata: 32'h0};
    memreq_q.push_back(m);
    for (int k = 4; k < 8; k++) begin
      m = '{we: 1'b0, be: 4'b1111, addr: 32'h0000_1000 + 32'(4 * k), wdata: 32'h0};
      memreq_q.push_back(m);
    end
    m = '{we: 1'b0, be: 4'b1111, addr: 32'h0000_2004, wdata: 32'h0};
    memreq_q.push_back(m);
    fork
      begin : lsu_driver
        int wl;
        for (int k = 0; k < 8; k++)
          apply_lsu(1'b0, F3_LW, 32'h0000_1000 + 32'(4 * k), 32'h0, 1'b1,
                    mem_read(32'h0000_1000 + 32'(4 * k)), 1'b0, 1'b0, 4'b1111, 32'h0, wl);
      end
      begin : fetch_driver
        int wf;
        for (int k = 0; k < 2; k++)
          apply_fetch(32'h0000_2000 + 32'(4 * k), mem_read(32'h0000_2000 + 32'(4 * k)), 1'b0, wf);
      end
    join
    wait_drained(40);

    // Reset while waiting in RESP; the late response must be dropped
    mem_auto = 1'b0;
    m = '{we: 1'b0, be: 4'b1111, addr: 32'h0000_0500, wdata: 32'h0};
    memreq_q.push_back(m);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0500;
    @(negedge clk);
    check_output("abort_if_gnt", bus.if_gnt_o, 32'h1);
    @(posedge clk);
    #1;
    bus.if_req_i = 1'b0;
    @(negedge clk);
    check_output("abort_mem_valid", bus.mem_valid_o, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset            = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h1111_1111;
    @(negedge clk);
    check_output("late_rvalid_if", bus.if_rvalid_o, 32'h0);
    check_output("late_rvalid_lsu", bus.lsu_rvalid_o, 32'h0);
    check_output("late_rvalid_busy", bus.mem_busy_o, 32'h0);
    check_output("late_rvalid_mem_valid", bus.mem_valid_o, 32'h0);
    @(posedge clk);
    #1;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    mem_auto         = 1'b1;
    apply_fetch(32'h0000_0600, mem_read(32'h0000_0600), 1'b1, w);
    check_output("post_abort_grant_wait", w, 32'd0);
    wait_drained(20);

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    // Misaligned word load is answered locally the cycle after grant
    apply_lsu(1'b0, F3_LW, 32'h0000_0102, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1,
              4'b1111, 32'h0, w);
    @(negedge clk);
    check_output("mis_mem_valid", bus.mem_valid_o, 32'h0);
    check_output("mis_lsu_rvalid", bus.lsu_rvalid_o, 32'h1);
    check_output("mis_flag", bus.lsu_misaligned_o, 32'h1);
    wait_drained(20);
`endif

    check_output("memreq_queue_empty", memreq_q.size(), 32'd0);
    check_output("if_resp_queue_empty", if_resp_q.size(), 32'd0);
    check_output("lsu_resp_queue_empty", lsu_resp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, maximum consecutive LSU grants while fetch waits (range 1..15).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req_i  input  1  fetch request; held with if_addr_i until if_gnt_o.
REQ-005 if_addr_i  input  32  fetch word address.
REQ-006 if_gnt_o  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid_o  output  1  fetch response valid (one-cycle pulse).
REQ-008 if_rdata_o  output  32  fetch response word.
REQ-009 lsu_req_i  input  1  LSU request; held with payload until lsu_gnt_o.
REQ-010 lsu_we_i  input  1  1 = store, 0 = load.
REQ-011 lsu_funct3_i  input  3  access width (core_package LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-012 lsu_addr_i  input  32  byte address.
REQ-013 lsu_wdata_i  input  32  store data, right-aligned.
REQ-014 lsu_gnt_o  output  1  LSU request accepted this cycle.
REQ-015 lsu_rvalid_o  output  1  LSU response valid (loads and store acks).
REQ-016 lsu_rdata_o  output  32  load data shifted to bit 0, not extended.
REQ-017 mem_busy_o  output  1  stall to memory stage while an LSU access is pending.
REQ-018 mem_valid_o / mem_ready_i  output / input  1 each  memory request handshake.
REQ-019 mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  output  1/4/32/32  request payload; mem_addr_o word-aligned.
REQ-020 mem_rvalid_i, mem_rdata_i  input  1/32  memory response.

Function
REQ-021 FSM states IDLE, REQ, RESP; one outstanding transaction.
REQ-022 IDLE: pick a winner among asserted requests; raise its gnt_o combinationally that cycle; latch payload and owner; go to REQ.
REQ-023 Priority: LSU wins unless the starvation counter equals STARVE_MAX and if_req_i is high, in which case fetch wins.
REQ-024 Starvation counter: increments on each LSU grant while if_req_i is high; clears on fetch grant or when if_req_i is low; saturates at STARVE_MAX.
REQ-025 REQ: mem_valid_o = 1 with latched payload stable; on mem_ready_i go to RESP.
REQ-026 RESP: on mem_rvalid_i, pulse the owner's rvalid_o the same cycle with data; go to IDLE; no grant in that cycle.
REQ-027 Minimum latency: grant cycle to rvalid = 2 cycles (ready and rvalid each in their first eligible cycle).
REQ-028 Byte enables: SB -> 4'b0001 << addr[1:0]; SH -> 4'b0011 << {addr[1],1'b0}; SW and all loads and fetches -> 4'b1111.
REQ-029 Store data is replicated into byte and half lanes; loads: lsu_rdata_o = mem_rdata_i >> (8*addr[1:0]).
REQ-030 mem_busy_o = (lsu_req_i or owner == LSU with state != IDLE) and not lsu_rvalid_o.
REQ-031 mem_rvalid_i in IDLE or REQ is ignored.

Reset
REQ-032 Reset forces IDLE, counter 0, all gnt/rvalid/mem_valid_o/mem_busy_o 0, payload registers 0; any in-flight transaction is abandoned.

Configuration
REQ-033 With MEM_ARB_MISALIGN_CHECK_EN defined: an LSU halfword access with addr[0] = 1 or word access with addr[1:0] != 0 is granted but not issued, and the next cycle lsu_rvalid_o = 1 with rdata 0 and an output lsu_misaligned_o = 1 for that cycle; without the macro the port is absent and accesses issue unchecked.

Structure
REQ-034 The FSM state enum and the byte-enable function belong in core_package; width codes reuse the existing funct3 constants.
REQ-035 One sub-module, mem_lane_align: byte enables, store lane replication and load right-shift (combinational).

Verification
REQ-036 Lone fetch at 0x100, ready and rvalid immediate, rdata 0xDEADBEEF -> if_gnt_o at t0, mem_valid_o at t1, if_rvalid_o with 0xDEADBEEF at t2.
REQ-037 SB addr 0x203 wdata 0xAB -> mem_be_o 4'b1000, mem_wdata_o 0xABABABAB, mem_addr_o 0x200, lsu_rvalid_o on ack.
REQ-038 LH addr 0x302, mem_rdata_i 0x8001_1234 -> lsu_rdata_o 0x0000_8001.
REQ-039 Fetch and LSU requesting continuously, STARVE_MAX 4 -> four LSU grants, then one fetch grant, repeating.
REQ-040 Reset asserted in RESP, late mem_rvalid_i next cycle -> no rvalid pulse, state IDLE, mem_busy_o 0.
REQ-041 With MEM_ARB_MISALIGN_CHECK_EN defined, LW addr 0x102 -> mem_valid_o stays 0, lsu_misaligned_o and lsu_rvalid_o high one cycle after grant.
